// File: rtl/ca_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ca_pkg
// Purpose  : Shared constants, FSM state encoding and byte-extraction helper
//            for the elementary cellular-automaton row engine.
// Revision : 1.0 - initial release
// ============================================================================
package ca_pkg;

  localparam int CA_CELLS  = 128;
  localparam int CA_ROWS   = 64;
  localparam int CA_COLS   = 16;
  localparam int CA_ADDR_W = 10;

  typedef enum logic [2:0] {
    ST_CLEAR = 3'd0,
    ST_SEED  = 3'd1,
    ST_IDLE  = 3'd2,
    ST_STEP  = 3'd3,
    ST_WRITE = 3'd4
  } ca_state_e;

  // Row bit CA_CELLS-1 holds cell 0, so byte 'col' is the slice starting at
  // the top once the row is shifted left by col*8; its MSB is the leftmost cell.
  function automatic logic [7:0] row_byte(input logic [CA_CELLS-1:0] row,
                                          input logic [3:0]          col);
    logic [CA_CELLS-1:0] shifted;
    shifted = row << {col, 3'b000};
    return shifted[CA_CELLS-1 -: 8];
  endfunction

endpackage
`default_nettype wire

// File: rtl/ca_next_row.sv
`default_nettype none
// ============================================================================
// Module   : ca_next_row
// Purpose  : Combinational next-generation function for a 128-cell row.
//            Row bit CA_CELLS-1-i holds cell i. Edge behaviour selected by
//            macro CA_WRAP_EN (toroidal row) or zero-padding when undefined.
// Revision : 1.0 - initial release
// ============================================================================
module ca_next_row
  import ca_pkg::*;
(
  input  logic [7:0]          rule,
  input  logic [CA_CELLS-1:0] row,
  output logic [CA_CELLS-1:0] next_row
);

  // Padding bits supply the out-of-range neighbours of cells 0 and 127.
  logic pad_left;
  logic pad_right;

`ifdef CA_WRAP_EN
  assign pad_left  = row[0];
  assign pad_right = row[CA_CELLS-1];
`else
  assign pad_left  = 1'b0;
  assign pad_right = 1'b0;
`endif

  // ext[j+2] is the left neighbour, ext[j+1] the cell, ext[j] the right one.
  logic [CA_CELLS+1:0] ext;
  assign ext = {pad_left, row, pad_right};

  genvar j;
  generate
    for (j = 0; j < CA_CELLS; j++) begin : g_cell
      assign next_row[j] = rule[{ext[j+2], ext[j+1], ext[j]}];
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/ca_row_engine.sv
`default_nettype none
// ============================================================================
// Module   : ca_row_engine
// Purpose  : Clears the 1024x8 debug RAM, writes a seed row, then writes one
//            new cellular-automaton generation per frame_tick into a 64-row
//            ring at address {row[5:0], col[3:0]}.
//            Optional macro CA_WRAP_EN (in ca_next_row) makes the row toroidal.
// Revision : 1.0 - initial release
// ============================================================================
module ca_row_engine
  import ca_pkg::*;
#(
  parameter logic [7:0] RULE      = 8'd30,
  parameter int         SEED_CELL = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 frame_tick,
  output logic                 ram_we,
  output logic [CA_ADDR_W-1:0] ram_addr,
  output logic [7:0]           ram_data,
  output logic                 busy,
  output logic [7:0]           gen_count
);

  localparam int ROW_W = $clog2(CA_ROWS);

  // Generation 0: only the seed cell is live (cell i lives at bit CA_CELLS-1-i).
  localparam logic [CA_CELLS-1:0] SEED_ROW =
    {1'b1, {(CA_CELLS-1){1'b0}}} >> SEED_CELL;

  ca_state_e           state;
  logic [CA_ADDR_W-1:0] clr_cnt;
  logic [3:0]           col;
  logic [CA_CELLS-1:0]  row;
  logic [CA_CELLS-1:0]  next_row;
  logic [ROW_W-1:0]     wr_row;

  // gen_count[5:0] is the ring row last written, so the new one goes just after it.
  assign wr_row = gen_count[ROW_W-1:0] + ROW_W'(1);

  ca_next_row u_next (
    .rule     (RULE),
    .row      (row),
    .next_row (next_row)
  );

  // Sequencer: clear, seed, then one step plus a 16-byte write per frame tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_CLEAR;
      clr_cnt   <= '0;
      col       <= '0;
      row       <= '0;
      gen_count <= '0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_data  <= '0;
      busy      <= 1'b1;
    end else begin
      case (state)
        ST_CLEAR: begin
          ram_we   <= 1'b1;
          ram_addr <= clr_cnt;
          ram_data <= 8'h00;
          busy     <= 1'b1;
          clr_cnt  <= clr_cnt + CA_ADDR_W'(1);
          if (&clr_cnt) begin
            state <= ST_SEED;
            row   <= SEED_ROW;
            col   <= '0;
          end
        end
        ST_SEED: begin
          ram_we   <= 1'b1;
          ram_addr <= {{ROW_W{1'b0}}, col};
          ram_data <= row_byte(row, col);
          busy     <= 1'b1;
          col      <= col + 4'd1;
          if (col == 4'(CA_COLS-1)) begin
            state <= ST_IDLE;
          end
        end
        ST_IDLE: begin
          ram_we <= 1'b0;
          // Ticks outside IDLE are simply never looked at.
          if (frame_tick) begin
            state <= ST_STEP;
            busy  <= 1'b1;
          end else begin
            busy  <= 1'b0;
          end
        end
        ST_STEP: begin
          ram_we <= 1'b0;
          busy   <= 1'b1;
          row    <= next_row;
          col    <= '0;
          state  <= ST_WRITE;
        end
        ST_WRITE: begin
          ram_we   <= 1'b1;
          ram_addr <= {wr_row, col};
          ram_data <= row_byte(row, col);
          busy     <= 1'b1;
          col      <= col + 4'd1;
          if (col == 4'(CA_COLS-1)) begin
            gen_count <= gen_count + 8'd1;
            state     <= ST_IDLE;
          end
        end
        default: begin
          state   <= ST_CLEAR;
          clr_cnt <= '0;
          col     <= '0;
          ram_we  <= 1'b0;
          busy    <= 1'b1;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ca_row_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_ca_row_engine
// Purpose  : Directed self-checking bench for ca_row_engine. A second instance
//            with SEED_CELL=0 exercises the row edges (CA_WRAP_EN aware).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ca_row_engine;

`ifdef CA_WRAP_EN
  localparam logic [7:0] EXP_EDGE31 = 8'h01;
`else
  localparam logic [7:0] EXP_EDGE31 = 8'h00;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       frame_tick;
  logic       we,  busy;
  logic [9:0] addr;
  logic [7:0] data, gc;
  logic       we0, busy0;
  logic [9:0] addr0;
  logic [7:0] data0, gc0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ca_row_engine dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick),
    .ram_we(we), .ram_addr(addr), .ram_data(data), .busy(busy), .gen_count(gc)
  );

  ca_row_engine #(.RULE(8'd30), .SEED_CELL(0)) dut0 (
    .clk(clk), .rst(rst), .frame_tick(frame_tick),
    .ram_we(we0), .ram_addr(addr0), .ram_data(data0), .busy(busy0), .gen_count(gc0)
  );

  // Drive a one-cycle tick; returns at the falling edge after the sampling edge.
  task automatic pulse_tick;
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    frame_tick = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({we, addr, data, busy, gc} !== {1'b0, 10'd0, 8'd0, 1'b1, 8'd0}) begin
      bad++;
      $display("FAIL reset_state: got we=%b addr=%0d data=%h busy=%b gen=%0d, want we=0 addr=0 data=00 busy=1 gen=0",
               we, addr, data, busy, gc);
    end
  endtask

  task automatic test_clear_seed;
    logic [9:0] ea;
    logic [7:0] ed;
    rst = 1'b0;
    for (int k = 1; k <= 1040; k++) begin
      @(negedge clk);
      ea = (k <= 1024) ? 10'(k - 1) : 10'(k - 1025);
      ed = (k == 1033) ? 8'h80 : 8'h00;
      total++;
      if ({we, addr, data, busy} !== {1'b1, ea, ed, 1'b1}) begin
        bad++;
        $display("FAIL clear_seed edge %0d: got we=%b addr=%0d data=%h busy=%b, want we=1 addr=%0d data=%h busy=1",
                 k, we, addr, data, busy, ea, ed);
      end
      if (k == 1025) begin
        total++;
        if ({we0, addr0, data0} !== {1'b1, 10'd0, 8'h80}) begin
          bad++;
          $display("FAIL seed_cell0: got we=%b addr=%0d data=%h, want we=1 addr=0 data=80", we0, addr0, data0);
        end
      end
    end
    @(negedge clk);
    total++;
    if ({we, busy, gc} !== {1'b0, 1'b0, 8'd0}) begin
      bad++;
      $display("FAIL idle_after_seed: got we=%b busy=%b gen=%0d, want we=0 busy=0 gen=0", we, busy, gc);
    end
  endtask

  task automatic test_one_tick;
    logic [7:0] ed, ed0;
    pulse_tick();
    @(negedge clk);
    total++;
    if ({we, busy} !== 2'b01) begin
      bad++;
      $display("FAIL step_cycle: got we=%b busy=%b, want we=0 busy=1", we, busy);
    end
    for (int j = 0; j < 16; j++) begin
      @(negedge clk);
      ed  = (j == 7) ? 8'h01 : (j == 8) ? 8'hC0 : 8'h00;
      ed0 = (j == 0) ? 8'hC0 : (j == 15) ? EXP_EDGE31 : 8'h00;
      total++;
      if ({we, addr, data} !== {1'b1, 10'(16 + j), ed}) begin
        bad++;
        $display("FAIL gen1 col %0d: got we=%b addr=%0d data=%h, want we=1 addr=%0d data=%h",
                 j, we, addr, data, 16 + j, ed);
      end
      total++;
      if ({we0, addr0, data0} !== {1'b1, 10'(16 + j), ed0}) begin
        bad++;
        $display("FAIL gen1_edge col %0d: got we=%b addr=%0d data=%h, want we=1 addr=%0d data=%h",
                 j, we0, addr0, data0, 16 + j, ed0);
      end
    end
    @(negedge clk);
    total++;
    if ({we, busy, gc, gc0} !== {1'b0, 1'b0, 8'd1, 8'd1}) begin
      bad++;
      $display("FAIL gen1_done: got we=%b busy=%b gen=%0d gen0=%0d, want we=0 busy=0 gen=1 gen0=1",
               we, busy, gc, gc0);
    end
  endtask

  task automatic test_ring_wrap;
    int         cnt;
    logic [9:0] first, last, efirst;
    for (int n = 2; n <= 64; n++) begin
      pulse_tick();
      cnt   = 0;
      first = '0;
      last  = '0;
      for (int c = 0; c < 40; c++) begin
        @(negedge clk);
        if (we) begin
          if (cnt == 0) first = addr;
          last = addr;
          cnt++;
        end
        if (!busy && !we) break;
      end
      efirst = 10'((n % 64) * 16);
      total++;
      if (cnt != 16 || first !== efirst || last !== efirst + 10'd15 || busy !== 1'b0) begin
        bad++;
        $display("FAIL ring gen %0d: got writes=%0d first=%0d last=%0d busy=%b, want writes=16 first=%0d last=%0d busy=0",
                 n, cnt, first, last, busy, efirst, efirst + 10'd15);
      end
    end
    total++;
    if (gc !== 8'd64) begin
      bad++;
      $display("FAIL ring_gen_count: got %0d, want 64", gc);
    end
  endtask

  task automatic test_tick_while_busy;
    int         cnt;
    logic [9:0] first;
    cnt   = 0;
    first = '0;
    for (int i = 0; i < 45; i++) begin
      frame_tick = (i == 0 || i == 5);
      @(negedge clk);
      if (we) begin
        if (cnt == 0) first = addr;
        cnt++;
      end
    end
    frame_tick = 1'b0;
    total++;
    if (cnt != 16 || first !== 10'd16 || gc !== 8'd65) begin
      bad++;
      $display("FAIL tick_while_busy: got writes=%0d first=%0d gen=%0d, want writes=16 first=16 gen=65",
               cnt, first, gc);
    end
  endtask

  task automatic test_rst_mid_write;
    pulse_tick();
    repeat (6) @(negedge clk);
    total++;
    if ({we, busy} !== 2'b11) begin
      bad++;
      $display("FAIL mid_write_state: got we=%b busy=%b, want we=1 busy=1", we, busy);
    end
    rst = 1'b1;
    @(negedge clk);
    total++;
    if ({we, addr, gc, busy} !== {1'b0, 10'd0, 8'd0, 1'b1}) begin
      bad++;
      $display("FAIL rst_mid_write: got we=%b addr=%0d gen=%0d busy=%b, want we=0 addr=0 gen=0 busy=1",
               we, addr, gc, busy);
    end
    rst = 1'b0;
    for (int k = 1; k <= 1024; k++) begin
      @(negedge clk);
      total++;
      if ({we, addr, data} !== {1'b1, 10'(k - 1), 8'h00}) begin
        bad++;
        $display("FAIL reclear edge %0d: got we=%b addr=%0d data=%h, want we=1 addr=%0d data=00",
                 k, we, addr, data, k - 1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_clear_seed();
    test_one_tick();
    test_ring_wrap();
    test_tick_while_busy();
    test_rst_mid_write();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL timeout: simulation exceeded 1 ms");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
